// File: rtl/predict_resolve_pkg.sv
// Shared widths and PC helper for the BTB predictor and its resolution side.
// Word PCs wrap modulo 2^PCW; statistics counters wrap modulo 2^CNTW.
package predict_resolve_pkg;

  localparam int PCW  = 13;
  localparam int CNTW = 32;

  typedef logic [PCW-1:0]  pc_t;
  typedef logic [CNTW-1:0] cnt_t;

  // Sequential successor of a word PC.
  // The top bit is dropped, so the successor of 2^PCW-1 is 0.
  function automatic pc_t pc_inc(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/pred_stage_reg.sv
// One pipeline stage register carrying {valid, pc, pred}.
// hold freezes the whole stage; kill loads a bubble in place of the incoming instruction.
module pred_stage_reg
  import predict_resolve_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic kill,
  input  logic src_valid,
  input  pc_t  src_pc,
  input  pc_t  src_pred,
  output logic valid,
  output pc_t  pc,
  output pc_t  pred
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      pred  <= '0;
    end else if (!hold) begin
      valid <= src_valid & ~kill;
      pc    <= src_pc;
      pred  <= src_pred;
    end
  end

endmodule

// File: rtl/predict_resolve.sv
// Branch-resolution side of the BTB predictor.
// Carries the PC and predicted next PC from F through D and E, checks each prediction, and emits
// redirect/update pairs, kill signals and miss statistics.
module predict_resolve
  import predict_resolve_pkg::*;
(
  input  logic CLK,
  input  logic RSTN,
  input  logic stall,
  input  logic validF,
  input  pc_t  pcF,
  input  pc_t  prepc,
  input  logic hit_predict,
  input  logic d_is_jal,
  input  logic d_is_ctrl,
  input  pc_t  d_jal_target,
  input  logic e_is_ctrl,
  input  logic e_taken,
  input  pc_t  e_target,
  output pc_t  pcD,
  output pc_t  nextpcD,
  output logic fail_predictD,
  output pc_t  pcE,
  output pc_t  nextpcE,
  output logic fail_predictE,
  output logic killF,
  output logic killD,
  output cnt_t cnt_resolved,
  output cnt_t cnt_miss
);

  logic valid_d, valid_e;
  pc_t  pc_d, pred_d, pc_e, pred_e;
  pc_t  pred_f, pred_to_e;
  pc_t  correct_d, actual_e;
  logic judge_d, raw_fail_d, resolve_e;

  assign pred_f = hit_predict ? prepc : pc_inc(pcF);

  pred_stage_reg u_fd (
    .clk       (CLK),
    .rst_n     (RSTN),
    .hold      (stall),
    .kill      (killF),
    .src_valid (validF),
    .src_pc    (pcF),
    .src_pred  (pred_f),
    .valid     (valid_d),
    .pc        (pc_d),
    .pred      (pred_d)
  );

  // A corrected D instruction carries its corrected next PC into E.
  // This stops the same instruction from failing a second time in E.
  assign pred_to_e = fail_predictD ? correct_d : pred_d;

  pred_stage_reg u_de (
    .clk       (CLK),
    .rst_n     (RSTN),
    .hold      (stall),
    .kill      (killD),
    .src_valid (valid_d),
    .src_pc    (pc_d),
    .src_pred  (pred_to_e),
    .valid     (valid_e),
    .pc        (pc_e),
    .pred      (pred_e)
  );

  // D judges only jal (known target) and non-control instructions.
  // A non-control instruction that predicts a jump means the BTB entry is an alias.
  always_comb begin
    judge_d    = valid_d & ~stall;
    correct_d  = d_is_jal ? d_jal_target : pc_inc(pc_d);
    raw_fail_d = 1'b0;
    if (judge_d) begin
      if (d_is_jal) begin
        raw_fail_d = (pred_d != d_jal_target);
      end else if (!d_is_ctrl) begin
        raw_fail_d = (pred_d != pc_inc(pc_d));
      end
    end
  end

  always_comb begin
    resolve_e     = valid_e & e_is_ctrl & ~stall;
    actual_e      = e_taken ? e_target : pc_inc(pc_e);
    fail_predictE = resolve_e & (actual_e != pred_e);
  end

  // The older instruction in E wins; the instruction in D is then on the wrong path.
  assign fail_predictD = raw_fail_d & ~fail_predictE;
  assign killF         = fail_predictD | fail_predictE;
  assign killD         = fail_predictE;

  assign pcD     = pc_d;
  assign pcE     = pc_e;
  assign nextpcD = fail_predictD ? correct_d : '0;
  assign nextpcE = fail_predictE ? actual_e  : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_resolved <= '0;
      cnt_miss     <= '0;
    end else begin
      if (resolve_e) cnt_resolved <= cnt_resolved + cnt_t'(1);
      if (killF)     cnt_miss     <= cnt_miss + cnt_t'(1);
    end
  end

endmodule

// File: tb/tb_predict_resolve.sv
// Directed bench for predict_resolve: each task drives one scenario and checks outputs inline.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time unit after that.
module tb_predict_resolve;
  import predict_resolve_pkg::*;

  logic CLK, RSTN, stall, validF, hit_predict;
  logic d_is_jal, d_is_ctrl, e_is_ctrl, e_taken;
  pc_t  pcF, prepc, d_jal_target, e_target;
  pc_t  pcD, nextpcD, pcE, nextpcE;
  logic fail_predictD, fail_predictE, killF, killD;
  cnt_t cnt_resolved, cnt_miss;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_miss = 0;
  int exp_res  = 0;

  predict_resolve dut (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .stall         (stall),
    .validF        (validF),
    .pcF           (pcF),
    .prepc         (prepc),
    .hit_predict   (hit_predict),
    .d_is_jal      (d_is_jal),
    .d_is_ctrl     (d_is_ctrl),
    .d_jal_target  (d_jal_target),
    .e_is_ctrl     (e_is_ctrl),
    .e_taken       (e_taken),
    .e_target      (e_target),
    .pcD           (pcD),
    .nextpcD       (nextpcD),
    .fail_predictD (fail_predictD),
    .pcE           (pcE),
    .nextpcE       (nextpcE),
    .fail_predictE (fail_predictE),
    .killF         (killF),
    .killD         (killD),
    .cnt_resolved  (cnt_resolved),
    .cnt_miss      (cnt_miss)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    stall = 0; validF = 0; pcF = '0; prepc = '0; hit_predict = 0;
    d_is_jal = 0; d_is_ctrl = 0; d_jal_target = '0;
    e_is_ctrl = 0; e_taken = 0; e_target = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 0;
    idle_inputs();
    #12;
    n_checks++; if (fail_predictD !== 1'b0 || fail_predictE !== 1'b0) $display("FAIL reset_fail: got D=%b E=%b want 0 0", fail_predictD, fail_predictE); else n_pass++;
    n_checks++; if (killF !== 1'b0 || killD !== 1'b0) $display("FAIL reset_kill: got F=%b D=%b want 0 0", killF, killD); else n_pass++;
    n_checks++; if (pcD !== 13'h0 || pcE !== 13'h0 || nextpcD !== 13'h0 || nextpcE !== 13'h0) $display("FAIL reset_pc: got %h %h %h %h want 0", pcD, pcE, nextpcD, nextpcE); else n_pass++;
    n_checks++; if (cnt_miss !== 32'd0 || cnt_resolved !== 32'd0) $display("FAIL reset_cnt: got %0d %0d want 0 0", cnt_miss, cnt_resolved); else n_pass++;
    @(negedge CLK);
    RSTN = 1;
  endtask

  task automatic test_btb_miss_branch();
    tick(); idle_inputs();
    validF = 1; pcF = 13'h0100; hit_predict = 0;
    tick(); idle_inputs();
    d_is_ctrl = 1;
    #1;
    n_checks++; if (fail_predictD !== 1'b0) $display("FAIL btb_d_nofail: got %b want 0", fail_predictD); else n_pass++;
    tick(); idle_inputs();
    e_is_ctrl = 1; e_taken = 1; e_target = 13'h0200;
    #1;
    n_checks++; if (fail_predictE !== 1'b1) $display("FAIL btb_fail_e: got %b want 1", fail_predictE); else n_pass++;
    n_checks++; if (pcE !== 13'h0100) $display("FAIL btb_pce: got %h want 0100", pcE); else n_pass++;
    n_checks++; if (nextpcE !== 13'h0200) $display("FAIL btb_nextpce: got %h want 0200", nextpcE); else n_pass++;
    n_checks++; if (killF !== 1'b1 || killD !== 1'b1) $display("FAIL btb_kill: got F=%b D=%b want 1 1", killF, killD); else n_pass++;
    exp_miss++; exp_res++;
    tick(); idle_inputs();
    #1;
    n_checks++; if (cnt_miss !== 32'(exp_miss)) $display("FAIL btb_cnt_miss: got %0d want %0d", cnt_miss, exp_miss); else n_pass++;
    n_checks++; if (cnt_resolved !== 32'(exp_res)) $display("FAIL btb_cnt_res: got %0d want %0d", cnt_resolved, exp_res); else n_pass++;
  endtask

  task automatic test_jal_in_d();
    tick(); idle_inputs();
    validF = 1; pcF = 13'h0040; hit_predict = 0;
    tick(); idle_inputs();
    d_is_jal = 1; d_is_ctrl = 1; d_jal_target = 13'h0080;
    #1;
    n_checks++; if (fail_predictD !== 1'b1) $display("FAIL jal_fail_d: got %b want 1", fail_predictD); else n_pass++;
    n_checks++; if (pcD !== 13'h0040 || nextpcD !== 13'h0080) $display("FAIL jal_pcs: got %h %h want 0040 0080", pcD, nextpcD); else n_pass++;
    n_checks++; if (killF !== 1'b1 || killD !== 1'b0) $display("FAIL jal_kill: got F=%b D=%b want 1 0", killF, killD); else n_pass++;
    exp_miss++;
    tick(); idle_inputs();
    #1;
    n_checks++; if (fail_predictE !== 1'b0 || fail_predictD !== 1'b0) $display("FAIL jal_e_nofail: got E=%b D=%b want 0 0", fail_predictE, fail_predictD); else n_pass++;
    // The corrected prediction must now match the jal target if E were to judge it.
    e_is_ctrl = 1; e_taken = 1; e_target = 13'h0080;
    #1;
    n_checks++; if (fail_predictE !== 1'b0) $display("FAIL jal_pred_corrected: got %b want 0", fail_predictE); else n_pass++;
    e_is_ctrl = 0; e_taken = 0;
    #1;
    n_checks++; if (cnt_miss !== 32'(exp_miss)) $display("FAIL jal_cnt_miss: got %0d want %0d", cnt_miss, exp_miss); else n_pass++;
  endtask

  task automatic test_simultaneous();
    tick(); idle_inputs();
    validF = 1; pcF = 13'h0300;
    tick(); idle_inputs();
    validF = 1; pcF = 13'h0301; d_is_ctrl = 1;
    tick(); idle_inputs();
    e_is_ctrl = 1; e_taken = 1; e_target = 13'h0400;
    d_is_jal = 1; d_is_ctrl = 1; d_jal_target = 13'h0500;
    #1;
    n_checks++; if (fail_predictE !== 1'b1 || fail_predictD !== 1'b0) $display("FAIL sim_prio: got E=%b D=%b want 1 0", fail_predictE, fail_predictD); else n_pass++;
    n_checks++; if (nextpcE !== 13'h0400 || pcE !== 13'h0300) $display("FAIL sim_e_pcs: got %h %h want 0300 0400", pcE, nextpcE); else n_pass++;
    n_checks++; if (killF !== 1'b1 || killD !== 1'b1) $display("FAIL sim_kill: got F=%b D=%b want 1 1", killF, killD); else n_pass++;
    exp_miss++; exp_res++;
    tick(); idle_inputs();
    #1;
    n_checks++; if (cnt_miss !== 32'(exp_miss)) $display("FAIL sim_cnt_miss: got %0d want %0d", cnt_miss, exp_miss); else n_pass++;
    n_checks++; if (dut.valid_e !== 1'b0) $display("FAIL sim_killed_d: got valid_e=%b want 0", dut.valid_e); else n_pass++;
  endtask

  task automatic test_stall();
    int pulses;
    pulses = 0;
    tick(); idle_inputs();
    validF = 1; pcF = 13'h0600;
    tick(); idle_inputs();
    d_is_ctrl = 1;
    tick(); idle_inputs();
    stall = 1; e_is_ctrl = 1; e_taken = 1; e_target = 13'h0700;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (fail_predictE === 1'b1) pulses++;
      n_checks++; if (fail_predictE !== 1'b0 || killF !== 1'b0) $display("FAIL stall_quiet%0d: got E=%b killF=%b want 0 0", i, fail_predictE, killF); else n_pass++;
      tick();
    end
    n_checks++; if (cnt_miss !== 32'(exp_miss) || cnt_resolved !== 32'(exp_res)) $display("FAIL stall_cnt_hold: got %0d %0d want %0d %0d", cnt_miss, cnt_resolved, exp_miss, exp_res); else n_pass++;
    stall = 0;
    #1;
    if (fail_predictE === 1'b1) pulses++;
    n_checks++; if (pcE !== 13'h0600 || nextpcE !== 13'h0700) $display("FAIL stall_release_pcs: got %h %h want 0600 0700", pcE, nextpcE); else n_pass++;
    exp_miss++; exp_res++;
    tick();
    #1;
    if (fail_predictE === 1'b1) pulses++;
    idle_inputs();
    n_checks++; if (pulses != 1) $display("FAIL stall_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (cnt_miss !== 32'(exp_miss) || cnt_resolved !== 32'(exp_res)) $display("FAIL stall_cnt: got %0d %0d want %0d %0d", cnt_miss, cnt_resolved, exp_miss, exp_res); else n_pass++;
  endtask

  task automatic test_wrap_alias();
    tick(); idle_inputs();
    validF = 1; pcF = 13'h1FFF; hit_predict = 0;
    tick(); idle_inputs();
    #1;
    n_checks++; if (dut.pred_d !== 13'h0000) $display("FAIL wrap_pred: got %h want 0000", dut.pred_d); else n_pass++;
    n_checks++; if (fail_predictD !== 1'b0 || pcD !== 13'h1FFF) $display("FAIL wrap_nofail: got fail=%b pcD=%h want 0 1fff", fail_predictD, pcD); else n_pass++;
    validF = 1; pcF = 13'h0050; hit_predict = 1; prepc = 13'h0123;
    tick(); idle_inputs();
    #1;
    n_checks++; if (fail_predictD !== 1'b1 || nextpcD !== 13'h0051) $display("FAIL alias_fail: got fail=%b nextpcD=%h want 1 0051", fail_predictD, nextpcD); else n_pass++;
    n_checks++; if (pcD !== 13'h0050 || killF !== 1'b1 || killD !== 1'b0) $display("FAIL alias_pc_kill: got %h F=%b D=%b want 0050 1 0", pcD, killF, killD); else n_pass++;
    exp_miss++;
    tick();
    #1;
    n_checks++; if (cnt_miss !== 32'(exp_miss) || fail_predictD !== 1'b0) $display("FAIL alias_cnt: got %0d fail=%b want %0d 0", cnt_miss, fail_predictD, exp_miss); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    tick(); idle_inputs();
    validF = 1; pcF = 13'h0010;
    tick(); idle_inputs();
    d_is_ctrl = 1;
    tick(); idle_inputs();
    e_is_ctrl = 1; e_taken = 1; e_target = 13'h0020;
    #1;
    n_checks++; if (fail_predictE !== 1'b1) $display("FAIL rst_pre_fail: got %b want 1", fail_predictE); else n_pass++;
    #1;
    RSTN = 0;
    #1;
    n_checks++; if (fail_predictE !== 1'b0 || killF !== 1'b0 || killD !== 1'b0) $display("FAIL rst_async_fail: got E=%b F=%b D=%b want 0 0 0", fail_predictE, killF, killD); else n_pass++;
    n_checks++; if (cnt_miss !== 32'd0 || cnt_resolved !== 32'd0) $display("FAIL rst_async_cnt: got %0d %0d want 0 0", cnt_miss, cnt_resolved); else n_pass++;
    n_checks++; if (dut.valid_d !== 1'b0 || dut.valid_e !== 1'b0) $display("FAIL rst_async_valid: got %b %b want 0 0", dut.valid_d, dut.valid_e); else n_pass++;
    n_checks++; if (pcE !== 13'h0 || nextpcE !== 13'h0) $display("FAIL rst_async_pc: got %h %h want 0 0", pcE, nextpcE); else n_pass++;
    idle_inputs();
    @(negedge CLK);
    RSTN = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_btb_miss_branch();
    test_jal_in_d();
    test_simultaneous();
    test_stall();
    test_wrap_alias();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
